// File: rtl/mem_access_pkg.sv
// Shared operation/state types and decode helpers for the Avalon load/store unit.
package mem_access_pkg;

   typedef enum logic [3:0] {LB, LBU, LH, LHU, LW, LWL, LWR, SB, SH, SW} mem_op_t;
   typedef enum logic [1:0] {IDLE, ISSUE, DATA, FAULT} state_t;

   function automatic logic is_load(input mem_op_t op);
      case (op)
         LB, LBU, LH, LHU, LW, LWL, LWR: return 1'b1;
         default:                        return 1'b0;
      endcase
   endfunction

   // Unknown encodings report as misaligned so they take the fault path.
   function automatic logic is_misaligned(input mem_op_t op, input logic [1:0] lo);
      case (op)
         LH, LHU, SH:           return lo[0];
         LW, SW:                return lo != 2'b00;
         LB, LBU, LWL, LWR, SB: return 1'b0;
         default:               return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/avalon_mem_access_if.sv
// Avalon-MM data-port signal bundle; master drives the request, slave answers.
interface avalon_mem_access_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) ();
   logic [ADDR_W-1:0]   address;
   logic                read;
   logic                write;
   logic                waitrequest;
   logic [DATA_W-1:0]   writedata;
   logic [DATA_W-1:0]   readdata;
   logic [DATA_W/8-1:0] byteenable;

   modport master (
      output address, read, write, writedata, byteenable,
      input  waitrequest, readdata
   );

   modport slave (
      input  address, read, write, writedata, byteenable,
      output waitrequest, readdata
   );
endinterface

// File: rtl/load_align.sv
// Formats a little-endian bus word into the register value for each load flavour.
module load_align
   import mem_access_pkg::*;
(
   input  mem_op_t     op,
   input  logic [1:0]  n,
   input  logic [31:0] w,
   input  logic [31:0] rt_old,
   output logic [31:0] y
);
   logic [4:0]         sh_l;
   logic [4:0]         sh_r;
   logic [7:0]         byte_u;
   logic [15:0]        half_u;
   logic signed [7:0]  byte_s;
   logic signed [15:0] half_s;

   always_comb begin
      sh_r   = {n, 3'b000};
      sh_l   = {2'd3 - n, 3'b000};
      byte_u = w[sh_r +: 8];
      half_u = n[1] ? w[31:16] : w[15:0];
      byte_s = byte_u;
      half_s = half_u;
      case (op)
         LB:      y = 32'(byte_s);
         LBU:     y = {24'h0, byte_u};
         LH:      y = 32'(half_s);
         LHU:     y = {16'h0, half_u};
         // Unaligned-word loads keep the register bytes the bus word does not reach.
         LWL:     y = (w << sh_l) | (rt_old & ((32'h1 << sh_l) - 32'h1));
         LWR:     y = (w >> sh_r) | (rt_old & ~(32'hFFFF_FFFF >> sh_r));
         default: y = w;
      endcase
   end
endmodule

// File: rtl/avalon_mem_access.sv
// Load/store unit: one MIPS memory op becomes one word-aligned Avalon-MM access.
// Bus outputs come from registered state so they hold steady through waitrequest.
module avalon_mem_access
   import mem_access_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  mem_op_t           op,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   input  logic [DATA_W-1:0] rt_old,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [DATA_W-1:0] rdata,
   avalon_mem_access_if.master bus
);
   state_t            state_q;
   state_t            state_d;
   logic              done_d;
   logic              err_d;
   logic              accept_req;
   logic              load_rdata;
   mem_op_t           op_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] rt_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] rdata_q;
   logic [DATA_W-1:0] align_y;
   logic [3:0]        be_q;

   function automatic logic [3:0] store_be(input mem_op_t o, input logic [1:0] lo);
      case (o)
         SB:      return 4'b0001 << lo;
         SH:      return lo[1] ? 4'b1100 : 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

   // Narrow stores replicate across lanes; byteenable picks the live one.
   function automatic logic [DATA_W-1:0] store_data(input mem_op_t o,
                                                    input logic [DATA_W-1:0] wd);
      case (o)
         SB:      return {4{wd[7:0]}};
         SH:      return {2{wd[15:0]}};
         SW:      return wd;
         default: return '0;
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         done    <= 1'b0;
         err     <= 1'b0;
      end else begin
         state_q <= state_d;
         done    <= done_d;
         err     <= err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      done_d     = 1'b0;
      err_d      = 1'b0;
      accept_req = 1'b0;
      load_rdata = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               accept_req = 1'b1;
               state_d    = is_misaligned(op, cpu_addr[1:0]) ? FAULT : ISSUE;
            end
         end
         ISSUE: begin
            if (!bus.waitrequest) begin
               if (is_load(op_q)) begin
                  state_d = DATA;
               end else begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         DATA: begin
            load_rdata = 1'b1;
            done_d     = 1'b1;
            state_d    = IDLE;
         end
         FAULT: begin
            done_d  = 1'b1;
            err_d   = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         op_q    <= LB;
         addr_q  <= '0;
         rt_q    <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         rdata_q <= '0;
      end else begin
         if (accept_req) begin
            op_q    <= op;
            addr_q  <= cpu_addr;
            rt_q    <= rt_old;
            wdata_q <= store_data(op, cpu_wdata);
            be_q    <= store_be(op, cpu_addr[1:0]);
         end
         if (load_rdata) begin
            rdata_q <= align_y;
         end
      end
   end

   load_align u_align (
      .op     (op_q),
      .n      (addr_q[1:0]),
      .w      (bus.readdata),
      .rt_old (rt_q),
      .y      (align_y)
   );

   assign busy           = (state_q != IDLE);
   assign rdata          = rdata_q;
   assign bus.address    = {addr_q[ADDR_W-1:2], 2'b00};
   assign bus.read       = (state_q == ISSUE) &&  is_load(op_q);
   assign bus.write      = (state_q == ISSUE) && !is_load(op_q);
   assign bus.writedata  = wdata_q;
   assign bus.byteenable = be_q;
endmodule

// File: tb/tb_avalon_mem_access.sv
// Directed bench for avalon_mem_access: a per-cycle expectation timeline built from
// the load/store rules is compared with the DUT outputs on every falling edge.
module tb_avalon_mem_access;
   import mem_access_pkg::*;

   localparam logic [31:0] JUNK = 32'h5A5A_C3C3;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   mem_op_t     op = LB;
   logic [31:0] cpu_addr = '0;
   logic [31:0] cpu_wdata = '0;
   logic [31:0] rt_old = '0;
   logic        busy;
   logic        done;
   logic        err;
   logic [31:0] rdata;

   avalon_mem_access_if bus ();

   avalon_mem_access dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .op        (op),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .rt_old    (rt_old),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .rdata     (rdata),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   int n_pass = 0;
   int n_total = 0;
   int rd_cnt = 0;
   int wr_cnt = 0;
   int done_cnt = 0;

   bit          chk_en = 1'b0;
   logic        exp_busy = 1'b0;
   logic        exp_done = 1'b0;
   logic        exp_err = 1'b0;
   logic        exp_read = 1'b0;
   logic        exp_write = 1'b0;
   logic [31:0] exp_rdata = '0;
   logic [31:0] exp_addr = '0;
   logic [31:0] exp_wd = '0;
   logic [3:0]  exp_be = '0;

   task automatic check1(input string name, input logic act, input logic expv);
      n_total++;
      if (act === expv) n_pass++;
      else $display("FAIL %s: got %b, want %b at %0t", name, act, expv, $time);
   endtask

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_total++;
      if (act === expv) n_pass++;
      else $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, expv, $time);
   endtask

   // ---------------- reference model (byte-level view of the rules) ----------------
   function automatic bit model_is_load(input mem_op_t o);
      return o inside {LB, LBU, LH, LHU, LW, LWL, LWR};
   endfunction

   function automatic bit model_misaligned(input mem_op_t o, input logic [31:0] a);
      int size = 1;
      case (o)
         LB, LBU, LWL, LWR, SB: size = 1;
         LH, LHU, SH:           size = 2;
         LW, SW:                size = 4;
         default:               return 1'b1;
      endcase
      return (a % size) != 0;
   endfunction

   function automatic logic [3:0] model_be(input mem_op_t o, input logic [31:0] a);
      int n = int'(a[1:0]);
      case (o)
         SB:      return 4'(1 << n);
         SH:      return (n >= 2) ? 4'hC : 4'h3;
         default: return 4'hF;
      endcase
   endfunction

   function automatic logic [31:0] model_wd(input mem_op_t o, input logic [31:0] wd);
      case (o)
         SB:      return {24'h0, wd[7:0]} * 32'h0101_0101;
         SH:      return {16'h0, wd[15:0]} * 32'h0001_0001;
         SW:      return wd;
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic [31:0] model_load(input mem_op_t o, input logic [31:0] a,
                                              input logic [31:0] w, input logic [31:0] rt);
      logic [7:0]  b [4];
      logic [7:0]  r [4];
      logic [31:0] v;
      int n = int'(a[1:0]);
      int k = (n / 2) * 2;
      for (int i = 0; i < 4; i++) begin
         b[i] = w[8*i +: 8];
         r[i] = rt[8*i +: 8];
      end
      v = 32'h0;
      case (o)
         LB, LBU: begin
            v = {24'h0, b[n]};
            if (o == LB && b[n][7]) v[31:8] = '1;
         end
         LH, LHU: begin
            v = {16'h0, b[k+1], b[k]};
            if (o == LH && b[k+1][7]) v[31:16] = '1;
         end
         LW: v = w;
         LWL: begin
            for (int i = 0; i < 4; i++) if (i >= 3 - n) r[i] = b[i - (3 - n)];
            v = {r[3], r[2], r[1], r[0]};
         end
         LWR: begin
            for (int i = 0; i < 4; i++) if (i <= 3 - n) r[i] = b[i + n];
            v = {r[3], r[2], r[1], r[0]};
         end
         default: v = 32'h0;
      endcase
      return v;
   endfunction

   // ---------------- per-cycle compare and event counters ----------------
   always @(negedge clk) begin
      if (bus.read)  rd_cnt++;
      if (bus.write) wr_cnt++;
      if (done)      done_cnt++;
      if (chk_en) begin
         check1("busy", busy, exp_busy);
         check1("done", done, exp_done);
         check1("err", err, exp_err);
         check1("read", bus.read, exp_read);
         check1("write", bus.write, exp_write);
         check32("rdata", rdata, exp_rdata);
         if (exp_read || exp_write) begin
            check32("address", bus.address, exp_addr);
            check32("writedata", bus.writedata, exp_wd);
            check32("byteenable", {28'h0, bus.byteenable}, {28'h0, exp_be});
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         step();
         exp_done = 1'b0;
         exp_err  = 1'b0;
      end
   endtask

   // Starts in an IDLE cycle, returns in the done cycle (so a follow-up can go back-to-back).
   task automatic txn(input mem_op_t o, input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] rt, input logic [31:0] rd, input int nwait,
                      input bit poke);
      bit          ld;
      bit          bad;
      logic [31:0] exp_r;
      ld    = model_is_load(o);
      bad   = model_misaligned(o, a);
      exp_r = model_load(o, a, rd, rt);
      start = 1'b1; op = o; cpu_addr = a; cpu_wdata = wd; rt_old = rt;
      step();
      start = poke;
      if (poke) begin
         op       = SW;
         cpu_addr = 32'hFFFF_FFF0;
      end
      exp_done = 1'b0;
      exp_err  = 1'b0;
      exp_busy = 1'b1;
      if (bad) begin
         step();
         exp_busy = 1'b0;
         exp_done = 1'b1;
         exp_err  = 1'b1;
      end else begin
         exp_read  = ld;
         exp_write = !ld;
         exp_addr  = {a[31:2], 2'b00};
         exp_be    = model_be(o, a);
         exp_wd    = model_wd(o, wd);
         for (int i = 0; i <= nwait; i++) begin
            bus.waitrequest = (i < nwait);
            step();
         end
         bus.waitrequest = 1'b0;
         exp_read  = 1'b0;
         exp_write = 1'b0;
         if (ld) begin
            bus.readdata = rd;
            step();
            bus.readdata = JUNK;
            exp_rdata    = exp_r;
         end
         exp_busy = 1'b0;
         exp_done = 1'b1;
      end
      start = 1'b0;
   endtask

   initial begin
      int rd0;
      int wr0;
      int dn0;
      bus.waitrequest = 1'b0;
      bus.readdata    = JUNK;

      // Hand-computed values that pin the model itself.
      check32("pin_lb",   model_load(LB,  32'h2, 32'h12F4_5678, 32'h0), 32'hFFFF_FFF4);
      check32("pin_lbu",  model_load(LBU, 32'h2, 32'h12F4_5678, 32'h0), 32'h0000_00F4);
      check32("pin_lh",   model_load(LH,  32'h2, 32'h12F4_5678, 32'h0), 32'h0000_12F4);
      check32("pin_lhu",  model_load(LHU, 32'h0, 32'h12F4_5678, 32'h0), 32'h0000_5678);
      check32("pin_lwl",  model_load(LWL, 32'h1, 32'hAABB_CCDD, 32'h1122_3344), 32'hCCDD_3344);
      check32("pin_lwr",  model_load(LWR, 32'h1, 32'hAABB_CCDD, 32'h1122_3344), 32'h11AA_BBCC);
      check32("pin_sb_wd", model_wd(SB, 32'h0000_00A5), 32'hA5A5_A5A5);
      check32("pin_sb_be", {28'h0, model_be(SB, 32'h8000_0003)}, 32'h0000_0008);

      // Reset state
      step();
      step();
      check1("rst_busy", busy, 1'b0);
      check1("rst_done", done, 1'b0);
      check1("rst_err", err, 1'b0);
      check1("rst_read", bus.read, 1'b0);
      check1("rst_write", bus.write, 1'b0);
      check32("rst_rdata", rdata, 32'h0);
      check32("rst_address", bus.address, 32'h0);
      check32("rst_writedata", bus.writedata, 32'h0);
      check32("rst_be", {28'h0, bus.byteenable}, 32'h0);
      reset  = 1'b0;
      chk_en = 1'b1;
      idle(1);

      // LW, no wait states
      rd0 = rd_cnt; dn0 = done_cnt;
      txn(LW, 32'h0000_0004, 32'h0, 32'h0, 32'hDEAD_BEEF, 0, 1'b0);
      check32("t1_rdata", rdata, 32'hDEAD_BEEF);
      idle(1);
      check32("t1_read_cycles", 32'(rd_cnt - rd0), 32'd1);
      check32("t1_done_pulses", 32'(done_cnt - dn0), 32'd1);

      // SB with two wait states; start pulses while busy must be ignored
      wr0 = wr_cnt; dn0 = done_cnt;
      txn(SB, 32'h8000_0003, 32'h0000_00A5, 32'h0, JUNK, 2, 1'b1);
      idle(1);
      check32("t2_write_cycles", 32'(wr_cnt - wr0), 32'd3);
      check32("t2_done_pulses", 32'(done_cnt - dn0), 32'd1);

      // Byte/half extension, issued back-to-back
      txn(LB,  32'h2, 32'h0, 32'h0, 32'h12F4_5678, 0, 1'b0);
      check32("t3_lb", rdata, 32'hFFFF_FFF4);
      txn(LBU, 32'h2, 32'h0, 32'h0, 32'h12F4_5678, 0, 1'b0);
      check32("t3_lbu", rdata, 32'h0000_00F4);
      txn(LH,  32'h2, 32'h0, 32'h0, 32'h12F4_5678, 1, 1'b0);
      check32("t3_lh", rdata, 32'h0000_12F4);
      txn(LHU, 32'h0, 32'h0, 32'h0, 32'h12F4_5678, 0, 1'b0);
      check32("t3_lhu", rdata, 32'h0000_5678);
      idle(1);

      // Misaligned and unknown ops fault without touching the bus
      rd0 = rd_cnt; wr0 = wr_cnt; dn0 = done_cnt;
      txn(LW, 32'h6, 32'h0, 32'h0, JUNK, 0, 1'b0);
      check1("t4_lw_err", err, 1'b1);
      txn(SH, 32'h1, 32'h1234_5678, 32'h0, JUNK, 0, 1'b0);
      check1("t4_sh_err", err, 1'b1);
      txn(mem_op_t'(4'hC), 32'h0, 32'h0, 32'h0, JUNK, 0, 1'b0);
      check1("t4_unk_err", err, 1'b1);
      check32("t4_rdata_held", rdata, 32'h0000_5678);
      idle(1);
      check32("t4_strobes", 32'(rd_cnt - rd0 + wr_cnt - wr0), 32'd0);
      check32("t4_done_pulses", 32'(done_cnt - dn0), 32'd3);

      // Unaligned-word merges and the remaining store shapes
      txn(LWL, 32'h1, 32'h0, 32'h1122_3344, 32'hAABB_CCDD, 0, 1'b0);
      check32("t5_lwl", rdata, 32'hCCDD_3344);
      txn(LWR, 32'h1, 32'h0, 32'h1122_3344, 32'hAABB_CCDD, 0, 1'b0);
      check32("t5_lwr", rdata, 32'h11AA_BBCC);
      txn(SH, 32'h2, 32'h1234_BEEF, 32'h0, JUNK, 1, 1'b0);
      txn(SW, 32'h8, 32'hCAFE_F00D, 32'h0, JUNK, 0, 1'b0);
      txn(SB, 32'h1, 32'h0000_003C, 32'h0, JUNK, 0, 1'b0);
      idle(1);

      // Reset while a read is stalled
      chk_en = 1'b0;
      start = 1'b1; op = LW; cpu_addr = 32'h10;
      step();
      start = 1'b0;
      bus.waitrequest = 1'b1;
      check1("t6_read_issue", bus.read, 1'b1);
      check1("t6_busy_issue", busy, 1'b1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      bus.waitrequest = 1'b0;
      check1("t6_read", bus.read, 1'b0);
      check1("t6_busy", busy, 1'b0);
      check1("t6_done", done, 1'b0);
      check32("t6_rdata", rdata, 32'h0);
      step();
      check1("t6_no_done", done, 1'b0);
      exp_busy = 1'b0; exp_done = 1'b0; exp_err = 1'b0;
      exp_read = 1'b0; exp_write = 1'b0; exp_rdata = 32'h0;
      chk_en = 1'b1;
      txn(LW, 32'h10, 32'h0, 32'h0, 32'h7654_3210, 0, 1'b0);
      check32("t6_after_rdata", rdata, 32'h7654_3210);
      idle(2);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
